// File: rtl/registers_bank_param.sv
// registers_bank_param
// --------------------------------------------------------------------------
// Parametrised register bank for the nRisc datapath. It holds NUM_REGS
// registers of DATA_W bits and has one synchronous write port and two
// combinational read ports. Each register also has a busy bit. A producer
// that needs several cycles sets the busy bit when it issues. The matching
// writeback clears it, so the control unit can stall on pending results.
//
// Options:
//   ZERO_REG = 1 : register 0 always reads 0, ignores writes, is never busy
//   BYPASS   = 1 : a valid write in this cycle is forwarded to any read port
//                  that reads the same register. That port then shows busy 0.
//
// Ports:
//   Clock               rising-edge clock for all state
//   Reset               synchronous, active-high; clears data and busy bits
//   RegWrite            write enable
//   Address             write address
//   WriteData           write data
//   Reg1_read/Reg2_read read addresses
//   Data1/Data2         read data (combinational)
//   Lock                set busy[LockAddr] at the next edge
//   LockAddr            register to mark busy
//   Busy1/Busy2         busy state of the register each read port addresses
//   AnyBusy             OR of all busy bits
// --------------------------------------------------------------------------
module registers_bank_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] Reg1_read,
  input  logic [ADDR_W-1:0] Reg2_read,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  input  logic              Lock,
  input  logic [ADDR_W-1:0] LockAddr,
  output logic              Busy1,
  output logic              Busy2,
  output logic              AnyBusy
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic                wr_en_s;
  logic                lk_en_s;
  logic [DATA_W-1:0]   data1_s;
  logic [DATA_W-1:0]   data2_s;
  logic                busy1_s;
  logic                busy2_s;

  // An address names real storage only if it is below NUM_REGS and is not
  // the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic ok;
    if (32'(a) >= 32'(NUM_REGS)) begin
      ok = 1'b0;
    end else if ((ZERO_REG != 0) && (a == '0)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  // Qualify the write and lock requests against the address range.
  always_comb begin
    wr_en_s = RegWrite & addr_ok(Address);
    lk_en_s = Lock & addr_ok(LockAddr);
  end

  // Next-state data and busy bits. A write clears busy first. A lock in the
  // same cycle then sets it again, so the newer producer wins.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      if (wr_en_s && (Address == ADDR_W'(i))) begin
        regs_d[i] = WriteData;
        busy_d[i] = 1'b0;
      end else begin
        regs_d[i] = regs_q[i];
      end
      if (lk_en_s && (LockAddr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else begin
        busy_d[i] = busy_d[i];
      end
    end
  end

  // State registers with synchronous reset taking priority over write and lock.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port 1: invalid or zero address gives 0, then forwarding, then storage.
  always_comb begin
    data1_s = '0;
    busy1_s = 1'b0;
    if (!addr_ok(Reg1_read)) begin
      data1_s = '0;
      busy1_s = 1'b0;
    end else if ((BYPASS != 0) && wr_en_s && (Address == Reg1_read)) begin
      data1_s = WriteData;
      busy1_s = 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data1_s = (Reg1_read == ADDR_W'(i)) ? regs_q[i] : data1_s;
        busy1_s = (Reg1_read == ADDR_W'(i)) ? busy_q[i] : busy1_s;
      end
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    data2_s = '0;
    busy2_s = 1'b0;
    if (!addr_ok(Reg2_read)) begin
      data2_s = '0;
      busy2_s = 1'b0;
    end else if ((BYPASS != 0) && wr_en_s && (Address == Reg2_read)) begin
      data2_s = WriteData;
      busy2_s = 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data2_s = (Reg2_read == ADDR_W'(i)) ? regs_q[i] : data2_s;
        busy2_s = (Reg2_read == ADDR_W'(i)) ? busy_q[i] : busy2_s;
      end
    end
  end

  assign Data1   = data1_s;
  assign Data2   = data2_s;
  assign Busy1   = busy1_s;
  assign Busy2   = busy2_s;
  assign AnyBusy = |busy_q;

endmodule

// File: tb/tb_registers_bank_param.sv
// Testbench for registers_bank_param. It drives two instances from the same
// stimulus:
//   u_a : defaults (4 regs, ZERO_REG=0, BYPASS=1)
//   u_b : 3 regs, ZERO_REG=1, BYPASS=0
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time
// unit later, well away from the next edge.
module tb_registers_bank_param;

  logic       clk;
  logic       rst;
  logic       reg_write;
  logic [1:0] address;
  logic [7:0] write_data;
  logic [1:0] r1;
  logic [1:0] r2;
  logic       lock;
  logic [1:0] lock_addr;

  logic [7:0] a_d1, a_d2, b_d1, b_d2;
  logic       a_b1, a_b2, a_any, b_b1, b_b2, b_any;

  int checks = 0;
  int errors = 0;

  registers_bank_param u_a (
    .Clock(clk), .Reset(rst), .RegWrite(reg_write), .Address(address),
    .WriteData(write_data), .Reg1_read(r1), .Reg2_read(r2),
    .Data1(a_d1), .Data2(a_d2), .Lock(lock), .LockAddr(lock_addr),
    .Busy1(a_b1), .Busy2(a_b2), .AnyBusy(a_any)
  );

  registers_bank_param #(
    .DATA_W(8), .NUM_REGS(3), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)
  ) u_b (
    .Clock(clk), .Reset(rst), .RegWrite(reg_write), .Address(address),
    .WriteData(write_data), .Reg1_read(r1), .Reg2_read(r2),
    .Data1(b_d1), .Data2(b_d2), .Lock(lock), .LockAddr(lock_addr),
    .Busy1(b_b1), .Busy2(b_b2), .AnyBusy(b_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; reg_write = 1'b0; lock = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reg_write = 1'b1; address = 2'd1; write_data = 8'hAA;
    lock = 1'b1; lock_addr = 2'd2; r1 = 2'd0; r2 = 2'd0;
    tick();
    idle();
    for (int a = 0; a < 4; a++) begin
      r1 = 2'(a); r2 = 2'(a);
      #1;
      checks++; if (a_d1 !== 8'h00 || a_d2 !== 8'h00) begin errors++; $display("FAIL reset_a_data addr=%0d: got %h/%h exp 00/00", a, a_d1, a_d2); end
      checks++; if (b_d1 !== 8'h00 || b_d2 !== 8'h00) begin errors++; $display("FAIL reset_b_data addr=%0d: got %h/%h exp 00/00", a, b_d1, b_d2); end
      checks++; if ({a_b1, a_b2, a_any, b_b1, b_b2, b_any} !== 6'b000000) begin errors++; $display("FAIL reset_busy addr=%0d: got %b exp 000000", a, {a_b1, a_b2, a_any, b_b1, b_b2, b_any}); end
    end
  endtask

  task automatic test_write_read();
    reg_write = 1'b1; address = 2'd2; write_data = 8'h5A; r1 = 2'd2; r2 = 2'd0;
    #1;
    checks++; if (a_d1 !== 8'h5A) begin errors++; $display("FAIL wr_bypass_a: got %h exp 5a", a_d1); end
    checks++; if (b_d1 !== 8'h00) begin errors++; $display("FAIL wr_nobypass_b: got %h exp 00", b_d1); end
    tick();
    address = 2'd3; write_data = 8'hC3; r1 = 2'd2; r2 = 2'd3;
    #1;
    checks++; if (a_d1 !== 8'h5A || b_d1 !== 8'h5A) begin errors++; $display("FAIL rd_reg2: got %h/%h exp 5a/5a", a_d1, b_d1); end
    checks++; if (a_d2 !== 8'hC3) begin errors++; $display("FAIL wr3_bypass_a: got %h exp c3", a_d2); end
    checks++; if (b_d2 !== 8'h00) begin errors++; $display("FAIL wr3_invalid_b: got %h exp 00", b_d2); end
    tick();
    idle();
    r1 = 2'd1;
    #1;
    checks++; if (a_d2 !== 8'hC3) begin errors++; $display("FAIL rd_reg3_a: got %h exp c3", a_d2); end
    checks++; if (b_d2 !== 8'h00 || b_b2 !== 1'b0) begin errors++; $display("FAIL rd_reg3_b: got %h/%b exp 00/0", b_d2, b_b2); end
    checks++; if (b_d1 !== 8'h00 || a_d1 !== 8'h00) begin errors++; $display("FAIL rd_reg1_untouched: got %h/%h exp 00/00", a_d1, b_d1); end
  endtask

  task automatic test_zero_reg();
    reg_write = 1'b1; address = 2'd0; write_data = 8'hFF;
    lock = 1'b1; lock_addr = 2'd0; r1 = 2'd0; r2 = 2'd2;
    #1;
    checks++; if (a_d1 !== 8'hFF) begin errors++; $display("FAIL zero_bypass_a: got %h exp ff", a_d1); end
    checks++; if (b_d1 !== 8'h00) begin errors++; $display("FAIL zero_read_b_wr: got %h exp 00", b_d1); end
    tick();
    idle();
    #1;
    checks++; if (b_d1 !== 8'h00 || b_b1 !== 1'b0 || b_any !== 1'b0) begin errors++; $display("FAIL zero_b: got %h/%b/%b exp 00/0/0", b_d1, b_b1, b_any); end
    checks++; if (a_d1 !== 8'hFF || a_b1 !== 1'b1 || a_any !== 1'b1) begin errors++; $display("FAIL reg0_a_lockwrite: got %h/%b/%b exp ff/1/1", a_d1, a_b1, a_any); end
    reg_write = 1'b1; address = 2'd0; write_data = 8'hFF;
    #1;
    checks++; if (a_b1 !== 1'b0) begin errors++; $display("FAIL reg0_a_fwd_busy: got %b exp 0", a_b1); end
    tick();
    idle();
    #1;
    checks++; if (a_any !== 1'b0) begin errors++; $display("FAIL reg0_a_cleared: got %b exp 0", a_any); end
  endtask

  task automatic test_scoreboard();
    lock = 1'b1; lock_addr = 2'd1; r1 = 2'd1; r2 = 2'd1;
    tick();
    idle();
    #1;
    checks++; if ({a_b1, a_b2, a_any} !== 3'b111) begin errors++; $display("FAIL lock_a: got %b exp 111", {a_b1, a_b2, a_any}); end
    checks++; if ({b_b1, b_b2, b_any} !== 3'b111) begin errors++; $display("FAIL lock_b: got %b exp 111", {b_b1, b_b2, b_any}); end
    reg_write = 1'b1; address = 2'd1; write_data = 8'h11;
    #1;
    checks++; if (a_b1 !== 1'b0 || a_d1 !== 8'h11 || a_any !== 1'b1) begin errors++; $display("FAIL wb_fwd_a: got %b/%h/%b exp 0/11/1", a_b1, a_d1, a_any); end
    checks++; if (b_b1 !== 1'b1 || b_d1 !== 8'h00) begin errors++; $display("FAIL wb_nofwd_b: got %b/%h exp 1/00", b_b1, b_d1); end
    tick();
    idle();
    #1;
    checks++; if (a_b1 !== 1'b0 || a_any !== 1'b0 || a_d1 !== 8'h11) begin errors++; $display("FAIL wb_done_a: got %b/%b/%h exp 0/0/11", a_b1, a_any, a_d1); end
    checks++; if (b_b1 !== 1'b0 || b_any !== 1'b0 || b_d1 !== 8'h11) begin errors++; $display("FAIL wb_done_b: got %b/%b/%h exp 0/0/11", b_b1, b_any, b_d1); end
  endtask

  task automatic test_simultaneous();
    lock = 1'b1; lock_addr = 2'd1; reg_write = 1'b1; address = 2'd1; write_data = 8'h22;
    r1 = 2'd1; r2 = 2'd2;
    tick();
    idle();
    #1;
    checks++; if (a_d1 !== 8'h22 || a_b1 !== 1'b1 || a_any !== 1'b1) begin errors++; $display("FAIL lockwr_a: got %h/%b/%b exp 22/1/1", a_d1, a_b1, a_any); end
    checks++; if (b_d1 !== 8'h22 || b_b1 !== 1'b1 || b_any !== 1'b1) begin errors++; $display("FAIL lockwr_b: got %h/%b/%b exp 22/1/1", b_d1, b_b1, b_any); end
    lock = 1'b1; lock_addr = 2'd1;
    tick();
    idle();
    #1;
    checks++; if (a_b1 !== 1'b1 || b_b1 !== 1'b1) begin errors++; $display("FAIL relock: got %b/%b exp 1/1", a_b1, b_b1); end
    lock = 1'b1; lock_addr = 2'd2; reg_write = 1'b1; address = 2'd1; write_data = 8'h44;
    tick();
    idle();
    #1;
    checks++; if ({a_b1, a_b2, a_any} !== 3'b011 || a_d1 !== 8'h44 || a_d2 !== 8'h5A) begin errors++; $display("FAIL split_a: got %b %h %h exp 011 44 5a", {a_b1, a_b2, a_any}, a_d1, a_d2); end
    checks++; if ({b_b1, b_b2, b_any} !== 3'b011 || b_d1 !== 8'h44 || b_d2 !== 8'h5A) begin errors++; $display("FAIL split_b: got %b %h %h exp 011 44 5a", {b_b1, b_b2, b_any}, b_d1, b_d2); end
    rst = 1'b1; lock = 1'b1; lock_addr = 2'd2;
    tick();
    idle();
    #1;
    checks++; if ({a_b2, a_any, b_b2, b_any} !== 4'b0000) begin errors++; $display("FAIL rst_lock_busy: got %b exp 0000", {a_b2, a_any, b_b2, b_any}); end
    checks++; if (a_d1 !== 8'h00 || a_d2 !== 8'h00 || b_d1 !== 8'h00 || b_d2 !== 8'h00) begin errors++; $display("FAIL rst_lock_data: got %h %h %h %h exp 00", a_d1, a_d2, b_d1, b_d2); end
  endtask

  task automatic test_non_pow2();
    reg_write = 1'b1; address = 2'd3; write_data = 8'h77; lock = 1'b1; lock_addr = 2'd3;
    r1 = 2'd3; r2 = 2'd0;
    #1;
    checks++; if (a_d1 !== 8'h77 || b_d1 !== 8'h00 || b_b1 !== 1'b0) begin errors++; $display("FAIL np2_same_cycle: got %h/%h/%b exp 77/00/0", a_d1, b_d1, b_b1); end
    tick();
    idle();
    #1;
    checks++; if (b_d1 !== 8'h00 || b_b1 !== 1'b0 || b_any !== 1'b0) begin errors++; $display("FAIL np2_b_addr3: got %h/%b/%b exp 00/0/0", b_d1, b_b1, b_any); end
    checks++; if (a_d1 !== 8'h77 || a_b1 !== 1'b1 || a_any !== 1'b1) begin errors++; $display("FAIL np2_a_addr3: got %h/%b/%b exp 77/1/1", a_d1, a_b1, a_any); end
    for (int a = 0; a < 3; a++) begin
      r2 = 2'(a);
      #1;
      checks++; if (b_d2 !== 8'h00 || a_d2 !== 8'h00) begin errors++; $display("FAIL np2_unchanged addr=%0d: got %h/%h exp 00/00", a, a_d2, b_d2); end
    end
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; address = 2'd0; write_data = 8'h00;
    r1 = 2'd0; r2 = 2'd0; lock = 1'b0; lock_addr = 2'd0;
    #1;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_simultaneous();
    test_non_pow2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/registers_bank_param.md
Name: registers_bank_param

Overview:
Parametrised successor to the two-entry 8-bit register bank. It provides NUM_REGS registers of DATA_W bits, two combinational read ports and one synchronous write port. It adds three features: an optional hardwired-zero register 0, optional same-cycle write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets the control unit stall on registers with an outstanding (multi-cycle) result. It sits between decode and writeback in the nRisc datapath.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 4, number of registers (2..256, need not be a power of 2)
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes, never busy
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports

Ports:
Clock  input  1  single clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; clears all registers and busy bits
RegWrite  input  1  write enable (writeback)
Address  input  ADDR_W  write address
WriteData  input  DATA_W  write data
Reg1_read  input  ADDR_W  read address, port 1
Reg2_read  input  ADDR_W  read address, port 2
Data1  output  DATA_W  read data, port 1 (combinational)
Data2  output  DATA_W  read data, port 2 (combinational)
Lock  input  1  mark register LockAddr busy (issue of a multi-cycle producer)
LockAddr  input  ADDR_W  register to mark busy
Busy1  output  1  register Reg1_read has a pending result
Busy2  output  1  register Reg2_read has a pending result
AnyBusy  output  1  OR of all busy bits

Behaviour:
- Reset (sampled at rising edge) has priority over RegWrite and Lock.
  - Next edge: all registers = 0, all busy bits = 0.
  - Reset in the same cycle as a write: the write is lost.
  - Reset mid-operation discards every pending lock.
- Outputs follow state combinationally, so immediately after reset: Data1 = Data2 = 0 (unless bypassed), Busy1 = Busy2 = AnyBusy = 0.
- Write: if RegWrite and not Reset, reg[Address] <= WriteData at the rising edge. The write is ignored if Address >= NUM_REGS, or if ZERO_REG=1 and Address = 0.
- Write completion clears busy[Address] at the same edge.
- Read, combinational, no latency:
  - DataN = 0 if the address is >= NUM_REGS, or if ZERO_REG=1 and the address is 0.
  - Otherwise, if BYPASS=1, RegWrite=1, Address = RegN_read and the write is valid: DataN = WriteData.
  - Otherwise DataN = reg[RegN_read].
  - BYPASS=0: read-during-write returns the old value; the new value is visible the cycle after the edge.
- Scoreboard:
  - Lock (not Reset, LockAddr valid, not the zero register) sets busy[LockAddr] at the edge.
  - Lock and RegWrite to the same address in the same cycle: busy ends SET (the new producer wins), and the data is still written.
  - Lock and RegWrite to different addresses: both take effect.
  - Lock on an already-busy register: stays busy (no count; one outstanding producer per register).
- BusyN = busy[RegN_read], forced 0 for an invalid or zero-register address.
  - With BYPASS=1, BusyN = 0 when a valid same-address write is present this cycle, because the data is forwarded.
  - With BYPASS=0, BusyN reflects the stored bit only.
- Both read ports may address the same register; the results are identical.
- No X propagation: every register has a defined reset value.

Test Plan:
1. Reset: drive Reset=1 for 1 edge, then read all addresses -> Data1 = Data2 = 0, Busy1 = Busy2 = AnyBusy = 0; an RegWrite=1 (Address=1, WriteData=8'hAA) in the reset cycle leaves reg1 = 0.
2. Write/read: write 8'h5A to reg2, then reg3 = 8'hC3; read ports 2/3 -> Data1 = 8'h5A, Data2 = 8'hC3 the cycle after each write. With BYPASS=1, a same-cycle read of reg2 during the write shows 8'h5A; with BYPASS=0 it shows the old value 0.
3. Zero register (ZERO_REG=1): write 8'hFF to reg0 -> Data1 = 0; Lock with LockAddr=0 -> Busy1 = 0, AnyBusy = 0.
4. Scoreboard: Lock reg1 -> next cycle Busy1 = 1 and AnyBusy = 1; write 8'h11 to reg1 -> same cycle Busy1 = 0 (BYPASS=1), Data1 = 8'h11; after the edge, busy bit clear.
5. Simultaneous events: Lock reg1 and RegWrite reg1 = 8'h22 in the same cycle -> after the edge reg1 = 8'h22 and busy[1] = 1; Lock reg2 plus Reset -> busy[2] = 0.
6. Non-power-of-2 (NUM_REGS=3, ADDR_W=2): write 8'h77 to address 3 -> ignored; read address 3 -> 0, Busy = 0; regs 0..2 unchanged.
